// File: rtl/uart1_rx.sv
// 8N1 serial receiver for the UART1 tx1 line: synchronizes rx1, samples each bit
// at its centre and presents received bytes with a one-cycle valid or framing-error strobe.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | line idle, waiting for rx_s low
//  START   | half-bit wait to confirm the start bit at its centre
//  DATA    | sampling 8 data bits, LSB first, one per bit period
//  STOP    | sampling the stop bit; good frame or framing error
//  BREAK   | stop bit was low; wait for the line to return high
module uart1_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx1,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q;
    logic             rx_s_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx1;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_TC) begin
                    cnt_d = '0;
                    // a line that is high again at mid-start was only a glitch
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_TC) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_TC) begin
                    cnt_d = '0;
                    // leaving at mid-stop-bit keeps a directly following start edge catchable
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart1_rx.sv
// Self-checking bench for uart1_rx: frames are driven bit-by-bit from a behavioural
// serial source and received bytes are compared against an expected-byte queue.
module tb_uart1_rx;

    localparam int C = 16;
    localparam int H = C / 2;
    localparam int LAT = 2 + H + 9 * C + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_drv = 1'b1;
    logic       tx1 = 1'b1;
    logic       loop_sel = 1'b0;
    logic       rx1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       rx_busy;

    assign rx1 = loop_sel ? tx1 : rx_drv;

    uart1_rx #(.CLKS_PER_BIT(C), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx1        (rx1),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // observation record, filled away from the active edge
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         err_pulses = 0;
    int         overlap = 0;
    int         wide_valid = 0;
    int         wide_err = 0;
    int         busy_seen = 0;
    int         busy_fall_bad = 0;
    logic       prev_valid = 1'b0;
    logic       prev_err = 1'b0;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        if (data_valid) begin
            got_q.push_back(data_out);
            got_cyc.push_back(cyc);
            if (rx_busy || !prev_busy) busy_fall_bad++;
        end
        if (frame_err) err_pulses++;
        if (data_valid && frame_err) overlap++;
        if (data_valid && prev_valid) wide_valid++;
        if (frame_err && prev_err) wide_err++;
        if (rx_busy) busy_seen++;
        prev_valid = data_valid;
        prev_err   = frame_err;
        prev_busy  = rx_busy;
    end

    logic [7:0] model_last;
    int         start_cyc;

    function automatic logic [7:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 8'hxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        got_cyc.delete();
        err_pulses    = 0;
        overlap       = 0;
        wide_valid    = 0;
        wide_err      = 0;
        busy_seen     = 0;
        busy_fall_bad = 0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx_drv    = 1'b0;
        start_cyc = cyc;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            tick(C);
        end
        rx_drv = stop_bit;
        tick(C);
    endtask

    // behavioural stand-in for the UART1 transmitter: one idle bit, then an 8N1 frame
    task automatic tx_send(input logic [7:0] d);
        tx1 = 1'b1;
        tick(C);
        tx1 = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            tx1 = d[i];
            tick(C);
        end
        tx1 = 1'b1;
        tick(C);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_drv = 1'b1;
        tick(3);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h exp 00", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", data_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b exp 0", frame_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", rx_busy); end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        clear_mon();
        tick(40);
        send_frame(8'hA5, 1'b1);
        tick(20);
        model_last = 8'hA5;
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d exp 1", got_q.size()); end
        checks++; if (got_at(0) !== 8'hA5) begin errors++; $display("FAIL basic_byte: got %h exp a5", got_at(0)); end
        checks++; if (err_pulses !== 0) begin errors++; $display("FAIL basic_ferr: got %0d exp 0", err_pulses); end
        checks++; if (busy_fall_bad !== 0) begin errors++; $display("FAIL basic_busy_fall: got %0d exp 0", busy_fall_bad); end
        checks++; if (data_out !== model_last) begin errors++; $display("FAIL basic_hold: got %h exp %h", data_out, model_last); end
    endtask

    task automatic test_false_start();
        clear_mon();
        rx_drv = 1'b0;
        tick(4);
        rx_drv = 1'b1;
        tick(40);
        checks++; if (busy_seen !== H) begin errors++; $display("FAIL false_busy_len: got %0d exp %0d", busy_seen, H); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL false_valid: got %0d exp 0", got_q.size()); end
        checks++; if (err_pulses !== 0) begin errors++; $display("FAIL false_ferr: got %0d exp 0", err_pulses); end
        checks++; if (data_out !== model_last) begin errors++; $display("FAIL false_data: got %h exp %h", data_out, model_last); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL false_idle: got %b exp 0", rx_busy); end
    endtask

    task automatic test_frame_error();
        clear_mon();
        send_frame(8'h3C, 1'b0);
        rx_drv = 1'b0;
        tick(50);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL ferr_break_busy: got %b exp 1", rx_busy); end
        rx_drv = 1'b1;
        tick(30);
        checks++; if (err_pulses !== 1) begin errors++; $display("FAIL ferr_count: got %0d exp 1", err_pulses); end
        checks++; if (wide_err !== 0) begin errors++; $display("FAIL ferr_width: got %0d exp 0", wide_err); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL ferr_no_valid: got %0d exp 0", got_q.size()); end
        checks++; if (data_out !== model_last) begin errors++; $display("FAIL ferr_data_held: got %h exp %h", data_out, model_last); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_idle: got %b exp 0", rx_busy); end
        send_frame(8'h81, 1'b1);
        tick(20);
        model_last = 8'h81;
        checks++; if (got_at(0) !== 8'h81) begin errors++; $display("FAIL ferr_next_byte: got %h exp 81", got_at(0)); end
        checks++; if (err_pulses !== 1) begin errors++; $display("FAIL ferr_next_clean: got %0d exp 1", err_pulses); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        int         s0;
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
        clear_mon();
        tick(20);
        send_frame(exp_b[0], 1'b1);
        s0 = start_cyc;
        send_frame(exp_b[1], 1'b1);
        send_frame(exp_b[2], 1'b1);
        tick(20);
        model_last = 8'h55;
        checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d exp 3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (got_at(i) !== exp_b[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h exp %h", i, got_at(i), exp_b[i]); end
        end
        checks++;
        if (got_cyc.size() == 0 || (got_cyc[0] - s0) !== LAT) begin
            errors++;
            $display("FAIL b2b_latency: got %0d exp %0d", (got_cyc.size() == 0) ? -1 : got_cyc[0] - s0, LAT);
        end
        checks++; if (wide_valid !== 0) begin errors++; $display("FAIL b2b_width: got %0d exp 0", wide_valid); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'hC3;
        clear_mon();
        rx_drv = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            rx_drv = d[i];
            tick(C);
        end
        rx_drv = d[4];
        tick(H);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b exp 1", rx_busy); end
        rst = 1'b1;
        tick(1);
        model_last = 8'h00;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h exp 00", data_out); end
        checks++; if (data_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_strobes: got %b%b exp 00", data_valid, frame_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b exp 0", rx_busy); end
        rst = 1'b0;
        rx_drv = 1'b1;
        tick(12 * C);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rstmid_no_valid: got %0d exp 0", got_q.size()); end
        send_frame(8'h5A, 1'b1);
        tick(20);
        model_last = 8'h5A;
        checks++; if (got_at(0) !== 8'h5A) begin errors++; $display("FAIL rstmid_next_byte: got %h exp 5a", got_at(0)); end
    endtask

    task automatic test_loopback();
        clear_mon();
        loop_sel = 1'b1;
        tx_send(8'h96);
        tx_send(8'h01);
        tick(20);
        loop_sel = 1'b0;
        model_last = 8'h01;
        checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL loop_count: got %0d exp 2", got_q.size()); end
        checks++; if (got_at(0) !== 8'h96) begin errors++; $display("FAIL loop_byte0: got %h exp 96", got_at(0)); end
        checks++; if (got_at(1) !== 8'h01) begin errors++; $display("FAIL loop_byte1: got %h exp 01", got_at(1)); end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] d;
        logic       bad;
        int         exp_err;
        exp_err = 0;
        clear_mon();
        tick(10);
        for (int n = 0; n < 14; n++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            send_frame(d, !bad);
            if (bad) begin
                exp_err++;
                rx_drv = 1'b1;
                tick(C + $urandom_range(0, 20));
            end else begin
                exp_q.push_back(d);
                model_last = d;
                if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 30));
            end
        end
        rx_drv = 1'b1;
        tick(30);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_at(i) !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d: got %h exp %h", i, got_at(i), exp_q[i]); end
        end
        checks++; if (err_pulses !== exp_err) begin errors++; $display("FAIL rand_ferr: got %0d exp %0d", err_pulses, exp_err); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL rand_overlap: got %0d exp 0", overlap); end
        checks++; if (wide_valid + wide_err !== 0) begin errors++; $display("FAIL rand_width: got %0d exp 0", wide_valid + wide_err); end
        checks++; if (data_out !== model_last) begin errors++; $display("FAIL rand_last: got %h exp %h", data_out, model_last); end
    endtask

    initial begin
        model_last = 8'h00;
        start_cyc  = 0;
        tick(1);
        test_reset();
        test_basic();
        test_false_start();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
